// File: rtl/bsg_ready_to_credit_flow_converter_decimated_if.sv
// ----------------------------------------------------------------------------
// bsg_ready_to_credit_flow_converter_decimated_if
//
// Bundles the producer-side ready/valid handshake and the link-side
// valid/data/credit signals of the ready-to-credit converter.
//
// Signals:
//   v_i      producer valid
//   data_i   producer payload (width_p bits)
//   ready_o  converter has at least one credit
//   v_o      link valid, one packet per asserted cycle
//   data_o   link payload (width_p bits)
//   credit_i credit token from the remote receiver
//
// Modports:
//   slave  - the converter's view (drives ready_o, v_o, data_o)
//   master - the environment's view (drives v_i, data_i, credit_i)
// ----------------------------------------------------------------------------
interface bsg_ready_to_credit_flow_converter_decimated_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               credit_i;

    modport slave (
        input  v_i,
        input  data_i,
        input  credit_i,
        output ready_o,
        output v_o,
        output data_o
    );

    modport master (
        output v_i,
        output data_i,
        output credit_i,
        input  ready_o,
        input  v_o,
        input  data_o
    );
endinterface

// File: rtl/bsg_ready_to_credit_flow_converter_decimated.sv
// ----------------------------------------------------------------------------
// bsg_ready_to_credit_flow_converter_decimated
//
// Sending end of a credit-flow channel. A local ready/valid producer is
// throttled by a credit counter; each credit_i pulse from the remote side
// restores decimation_p credits at once. Credit-return overflow saturates the
// counter at credit_max_val_p and raises a sticky overflow flag.
//
// Ports:
//   clk_i        clock, all state updates on posedge
//   reset_i      synchronous active-high reset
//   link         slave modport: v_i, data_i, credit_i in; ready_o, v_o, data_o out
//   credit_cnt_o current credit count
//   overflow_o   sticky credit-overflow error, cleared only by reset
//
// Build option:
//   BSG_READY_TO_CREDIT_OUTPUT_REG_EN - when defined, v_o/data_o are flopped
//   (1-cycle latency); otherwise they are combinational pass-throughs.
//   Credit accounting is identical in both builds.
// ----------------------------------------------------------------------------
module bsg_ready_to_credit_flow_converter_decimated #(
    parameter int width_p          = 32,
    parameter int credit_initial_p = 8,
    parameter int credit_max_val_p = 8,
    parameter int decimation_p     = 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    bsg_ready_to_credit_flow_converter_decimated_if.slave link,
    output logic [$clog2(credit_max_val_p+1)-1:0]     credit_cnt_o,
    output logic                                      overflow_o
);
    localparam int cw = $clog2(credit_max_val_p + 1);

    localparam logic [cw:0]   max_lp  = (cw+1)'(credit_max_val_p);
    localparam logic [cw:0]   dec_lp  = (cw+1)'(decimation_p);
    localparam logic [cw-1:0] init_lp = cw'(credit_initial_p);

    // Clamp the widened next-count back into the counter range.
    function automatic logic [cw-1:0] sat_count(input logic [cw:0] s);
        return (s > max_lp) ? max_lp[cw-1:0] : s[cw-1:0];
    endfunction

    function automatic logic is_overflow(input logic [cw:0] s);
        return (s > max_lp);
    endfunction

    logic [cw-1:0] count_r;
    logic          overflow_r;
    logic          ready;
    logic          xfer;
    logic [cw:0]   sum;

    // ---- stage p0: accept and credit accounting ----
    // ready depends on the registered count only, never on v_i.
    assign ready = (count_r != '0);
    assign xfer  = link.v_i & ready;

    // One extra bit so a credit return past max is visible; xfer only
    // happens with count >= 1, so the subtraction never wraps.
    assign sum = {1'b0, count_r}
               - {{cw{1'b0}}, xfer}
               + (link.credit_i ? dec_lp : '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r    <= init_lp;
            overflow_r <= 1'b0;
        end else begin
            count_r <= sat_count(sum);
            if (is_overflow(sum)) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign link.ready_o = ready;
    assign credit_cnt_o = count_r;
    assign overflow_o   = overflow_r;

`ifdef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
    // ---- stage p1: registered link outputs ----
    logic               v_p1;
    logic [width_p-1:0] data_p1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_p1    <= 1'b0;
            data_p1 <= '0;
        end else begin
            v_p1 <= xfer;
            if (xfer) begin
                data_p1 <= link.data_i;
            end
        end
    end

    assign link.v_o    = v_p1;
    assign link.data_o = data_p1;
`else
    assign link.v_o    = xfer;
    assign link.data_o = link.data_i;
`endif

endmodule

// File: tb/tb_bsg_ready_to_credit_flow_converter_decimated.sv
module tb_bsg_ready_to_credit_flow_converter_decimated;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    bsg_ready_to_credit_flow_converter_decimated_if #(.width_p(32)) ia ();
    bsg_ready_to_credit_flow_converter_decimated_if #(.width_p(32)) ib ();

    logic [3:0] cnt_a, cnt_b;
    logic       ovf_a, ovf_b;

    // A: init 8, max 8, decimation 1
    bsg_ready_to_credit_flow_converter_decimated #(
        .width_p(32), .credit_initial_p(8), .credit_max_val_p(8), .decimation_p(1)
    ) dut_a (
        .clk_i(clk), .reset_i(reset), .link(ia), .credit_cnt_o(cnt_a), .overflow_o(ovf_a)
    );

    // B: init 0, max 8, decimation 4
    bsg_ready_to_credit_flow_converter_decimated #(
        .width_p(32), .credit_initial_p(0), .credit_max_val_p(8), .decimation_p(4)
    ) dut_b (
        .clk_i(clk), .reset_i(reset), .link(ib), .credit_cnt_o(cnt_b), .overflow_o(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.v_i = 0; ia.data_i = '0; ia.credit_i = 0;
        ib.v_i = 0; ib.data_i = '0; ib.credit_i = 0;

        // reset
        reset = 1;
        cyc(); cyc();
        reset = 0;
        #1;
        chk("rst_cnt_a",   32'(cnt_a), 32'd8);
        chk("rst_ready_a", 32'(ia.ready_o), 32'd1);
        chk("rst_ovf_a",   32'(ovf_a), 32'd0);
        chk("rst_cnt_b",   32'(cnt_b), 32'd0);
        chk("rst_ready_b", 32'(ib.ready_o), 32'd0);
`ifdef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
        chk("rst_v_o_a",    32'(ia.v_o), 32'd0);
        chk("rst_data_o_a", ia.data_o, 32'd0);
`endif

        // drain all 8 credits with v_i held; two extra cycles must not transfer
        for (int i = 0; i < 10; i++) begin
            ia.v_i = 1; ia.data_i = 32'h100 + 32'(i);
            #1;
            chk("drain_ready", 32'(ia.ready_o), (i < 8) ? 32'd1 : 32'd0);
            chk("drain_cnt",   32'(cnt_a), (i < 8) ? 32'(8 - i) : 32'd0);
`ifndef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
            chk("drain_v_o", 32'(ia.v_o), (i < 8) ? 32'd1 : 32'd0);
            if (i < 8) chk("drain_data_o", ia.data_o, 32'h100 + 32'(i));
`endif
            cyc();
`ifdef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
            chk("drain_v_o", 32'(ia.v_o), (i < 8) ? 32'd1 : 32'd0);
            chk("drain_data_o", ia.data_o, 32'h100 + 32'((i < 8) ? i : 7));
`endif
        end
        ia.v_i = 0;
        #1;
        chk("empty_cnt",   32'(cnt_a), 32'd0);
        chk("empty_ready", 32'(ia.ready_o), 32'd0);
        chk("empty_v_o",   32'(ia.v_o), 32'd0);

        // return 8 single credits
        for (int k = 0; k < 8; k++) begin
            ia.credit_i = 1;
            cyc();
            chk("refill_cnt", 32'(cnt_a), 32'(k + 1));
        end
        ia.credit_i = 0;
        chk("refill_ovf", 32'(ovf_a), 32'd0);

        // at max: simultaneous transfer and credit nets to zero, no overflow
        ia.v_i = 1; ia.credit_i = 1; ia.data_i = 32'h55;
        cyc();
        ia.v_i = 0; ia.credit_i = 0;
        chk("max_xfer_cnt", 32'(cnt_a), 32'd8);
        chk("max_xfer_ovf", 32'(ovf_a), 32'd0);

        // at max: credit alone overflows, saturates, and sticks
        ia.credit_i = 1;
        cyc();
        ia.credit_i = 0;
        chk("ovf_cnt",  32'(cnt_a), 32'd8);
        chk("ovf_flag", 32'(ovf_a), 32'd1);
        ia.v_i = 1;
        cyc(); cyc();
        ia.v_i = 0;
        chk("ovf_sticky", 32'(ovf_a), 32'd1);
        chk("ovf_cnt_after_xfers", 32'(cnt_a), 32'd6);
        reset = 1;
        cyc();
        reset = 0;
        chk("ovf_clear", 32'(ovf_a), 32'd0);
        chk("ovf_reload", 32'(cnt_a), 32'd8);

        // decimated return on B: credit with v_i already high cannot transfer same cycle
        ib.v_i = 1; ib.credit_i = 1; ib.data_i = 32'h200;
        #1;
        chk("dec_no_same_cycle", 32'(ib.ready_o), 32'd0);
`ifndef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
        chk("dec_no_v_o", 32'(ib.v_o), 32'd0);
`endif
        cyc();
        ib.credit_i = 0;
        chk("dec_cnt4",   32'(cnt_b), 32'd4);
        chk("dec_ready",  32'(ib.ready_o), 32'd1);
        for (int j = 0; j < 5; j++) begin
            ib.data_i = 32'h300 + 32'(j);
            cyc();
            chk("dec_drain_cnt", 32'(cnt_b), (j < 4) ? 32'(3 - j) : 32'd0);
`ifdef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
            chk("dec_drain_v_o", 32'(ib.v_o), (j < 4) ? 32'd1 : 32'd0);
`endif
        end
        ib.v_i = 0;
        chk("dec_empty_ready", 32'(ib.ready_o), 32'd0);
        chk("dec_ovf", 32'(ovf_b), 32'd0);

        // output latency and reset of the link outputs
        ia.v_i = 1; ia.data_i = 32'hA5;
        #1;
`ifndef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
        chk("a5_v_o_comb",    32'(ia.v_o), 32'd1);
        chk("a5_data_o_comb", ia.data_o, 32'hA5);
`endif
        cyc();
        ia.v_i = 0;
        chk("a5_cnt", 32'(cnt_a), 32'd7);
`ifdef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
        chk("a5_v_o_reg",    32'(ia.v_o), 32'd1);
        chk("a5_data_o_reg", ia.data_o, 32'hA5);
`endif
        reset = 1;
        cyc();
        reset = 0;
        chk("a5_rst_v_o", 32'(ia.v_o), 32'd0);
        chk("a5_rst_cnt", 32'(cnt_a), 32'd8);
`ifdef BSG_READY_TO_CREDIT_OUTPUT_REG_EN
        chk("a5_rst_data_o", ia.data_o, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
